simon_key_schedule: RTL and testbench
=====================================

# simon_key_schedule

- Generates the 32 round keys of Simon 32/64 from a 64-bit master key, one 16-bit key per cycle.
- Sits directly upstream of the round-function (encrypt) stage.
- Shares that stage's `start` pulse: round key r appears in exactly the cycle the round stage performs round r, so no buffering of the 32-key set is needed.

## Interface
Parameters:
- `ROUNDS`, 32: number of round keys emitted per run. Fixed by Simon 32/64; not intended to be overridden.
- `C_CONST`, 16'hFFFC: schedule constant c = 2^16 − 4.

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse; captures `key` and begins a run. The same pulse drives the round stage.
- `key` input 64: master key. `key[15:0]`=k0, `key[31:16]`=k1, `key[47:32]`=k2, `key[63:48]`=k3. Sampled only in the `start` cycle.
- `round_key` output 16: current round key; 0 when `key_valid`=0.
- `key_valid` output 1: high during the 32 cycles carrying round keys 0..31.
- `round_idx` output 5: index of the key on `round_key`; 0 when idle.
- `done` output 1: one-cycle pulse in the cycle after round key 31.

## Operation
- Four 16-bit registers w0..w3 form a key window; `round_key` = w0 while running.
- 5-bit counter `round_idx`.
- FSM state IDLE:
  - `key_valid`=0, `round_key`=0, `round_idx`=0.
  - On `start`: w0..w3 ← k0..k3, `round_idx` ← 0, go to RUN.
- FSM state RUN:
  - `key_valid`=1.
  - Each cycle, new word n = C_CONST ^ z0[`round_idx`] ^ w0 ^ t ^ ROR1(t), where t = ROR3(w3) ^ w1. ROR is a 16-bit rotate right. z0[j] is bit 0 of the 16-bit constant.
  - Shift: w0←w1, w1←w2, w2←w3, w3←n.
  - `round_idx` increments.
  - When `round_idx`==31: go to DONE.
- FSM state DONE:
  - One cycle only; `done`=1, `key_valid`=0, `round_key`=0.
  - Then go to IDLE. `start` in this cycle is honoured, as in IDLE.
- z0 is a 62-bit sequence; z0[j] is the j-th character from the left of 11111010001001010110000111001101111101000100101011000011100110. Index j = `round_idx` (0..31, always < 62). Words generated for j ≥ 28 are never emitted, but the logic still computes them without special-casing.
- `start` while in RUN: abort the current run and restart from the new `key`. The next cycle shows round 0 of the new key; `done` is not raised for the aborted run.
- `reset` overrides `start`. State goes to IDLE, all registers clear, all outputs 0.
- `key` changes after the `start` cycle have no effect on the current run.

## Timing
- `start` in cycle T → round key r (r=0..31) on `round_key` in cycle T+1+r, with `key_valid`=1 and `round_idx`=r.
- `done`=1 in cycle T+33.
- Minimum restart interval: 1 cycle; back-to-back `start` is legal.
- All outputs come from registers or from w0 gated by state. No combinational path from `key` or `start` to any output.
- Reset values: `round_key`=0, `key_valid`=0, `round_idx`=0, `done`=0; state IDLE.
- Critical path: one ROR/XOR chain of 16 bits, 5 XOR levels. No multi-cycle paths.

## Test plan
- Standard vector. Key 64'h1918_1110_0908_0100, `start` at T → `round_key` = 0100, 0908, 1110, 1918, 71C3 in cycles T+1..T+5. `key_valid` is high T+1..T+32, `done` is high only at T+33.
- Integration with the round stage. Same key and `start`, plaintext 32'h6565_6877 → ciphertext 32'hC69B_E9BB. Keys 0..31 are consumed in lockstep; no extra registering between the stages.
- Restart mid-run. Second `start` at T+10 with key 0 → cycle T+11 shows `round_key`=0000, `round_idx`=0. `done` first appears at T+43 and not at T+33.
- Reset mid-run. `reset` at T+15 → from T+16, `round_key`=0, `key_valid`=0, `round_idx`=0. No `done` until a new `start`.
- Start in DONE cycle. `start` at T+33 → `done`=1 at T+33 and round 0 of the new key at T+34.
- Key isolation. Change `key` every cycle after `start` → round-key sequence identical to the standard vector.

Source files
------------

// File: rtl/simon_key_schedule.sv
// Simon 32/64 key schedule: expands a 64-bit master key into 32 round keys,
// one per cycle, in lockstep with the round stage that shares its start pulse.
module simon_key_schedule #(
    parameter int          ROUNDS  = 32,
    parameter logic [15:0] C_CONST = 16'hFFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] key,
    output logic [15:0] round_key,
    output logic        key_valid,
    output logic [4:0]  round_idx,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // z0 with index 0 at the leftmost character
    localparam logic [0:61] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    state_t      r_state;
    logic [15:0] r_w0;
    logic [15:0] r_w1;
    logic [15:0] r_w2;
    logic [15:0] r_w3;
    logic [4:0]  r_idx;
    logic        r_valid;
    logic        r_done;

    logic [15:0] w_t;
    logic [15:0] w_new;

    assign w_t   = {r_w3[2:0], r_w3[15:3]} ^ r_w1;
    assign w_new = C_CONST ^ {15'd0, Z0[r_idx]} ^ r_w0
                 ^ w_t ^ {w_t[0], w_t[15:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_state <= S_RUN;
            r_w0    <= key[15:0];
            r_w1    <= key[31:16];
            r_w2    <= key[47:32];
            r_w3    <= key[63:48];
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_w0 <= r_w1;
                    r_w1 <= r_w2;
                    r_w2 <= r_w3;
                    r_w3 <= w_new;
                    if (r_idx == LAST) begin
                        r_state <= S_DONE;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign round_key = r_valid ? r_w0 : 16'd0;
    assign key_valid = r_valid;
    assign round_idx = r_idx;
    assign done      = r_done;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule; all 32 keys are exercised through a
// Simon 32/64 round function against the published test vector.
module tb_simon_key_schedule;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic [15:0] round_key;
    logic        key_valid;
    logic [4:0]  round_idx;
    logic        done;

    int n_tests;
    int n_fail;

    logic [15:0] rk [32];

    localparam logic [63:0] KSTD = 64'h1918_1110_0908_0100;
    localparam logic [31:0] PT   = 32'h6565_6877;
    localparam logic [31:0] CT   = 32'hC69B_E9BB;

    simon_key_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .round_key (round_key),
        .key_valid (key_valid),
        .round_idx (round_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start is high in the current cycle; returns one cycle later
    task automatic fire(input logic [63:0] k);
        start = 1'b1;
        key   = k;
        step();
        start = 1'b0;
    endtask

    function automatic logic [15:0] rol(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] pt);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] tmp;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ rk[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    // called in cycle T+1; returns in cycle T+33
    task automatic collect(input string tag, input bit scramble);
        for (int r = 0; r < 32; r++) begin
            check({tag, "_valid"}, key_valid, 1'b1);
            check({tag, "_idx"}, round_idx, r[4:0]);
            check({tag, "_nodone"}, done, 1'b0);
            rk[r] = round_key;
            if (scramble) key = {$urandom, $urandom};
            step();
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_dvalid"}, key_valid, 1'b0);
        check({tag, "_dkey"}, round_key, 16'h0);
    endtask

    task automatic check_std_head(input string tag);
        check({tag, "_k0"}, rk[0], 16'h0100);
        check({tag, "_k1"}, rk[1], 16'h0908);
        check({tag, "_k2"}, rk[2], 16'h1110);
        check({tag, "_k3"}, rk[3], 16'h1918);
        check({tag, "_k4"}, rk[4], 16'h71C3);
    endtask

    initial begin
        int dones;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        key     = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_key", round_key, 16'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_idx", round_idx, 5'd0);
        check("rst_done", done, 1'b0);
        step();

        // standard vector plus encryption through all 32 keys
        fire(KSTD);
        collect("std", 1'b0);
        check_std_head("std");
        check("std_ct", encrypt(PT), CT);
        step();
        check("std_done_pulse", done, 1'b0);
        check("std_idle_idx", round_idx, 5'd0);

        // restart at T+10 with an all-zero key
        fire(KSTD);
        for (int i = 0; i < 9; i++) step();
        fire(64'h0);
        collect("rst10", 1'b0);
        check("z_k0", rk[0], 16'h0000);
        check("z_k3", rk[3], 16'h0000);
        check("z_k4", rk[4], 16'hFFFD);
        check("z_k5", rk[5], 16'h9FFD);

        // start in the DONE cycle
        fire(KSTD);
        collect("indone", 1'b0);
        check_std_head("indone");
        check("indone_ct", encrypt(PT), CT);
        step();

        // reset mid-run
        fire(KSTD);
        for (int i = 0; i < 14; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_key", round_key, 16'h0);
        check("mr_valid", key_valid, 1'b0);
        check("mr_idx", round_idx, 5'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || key_valid) dones++;
            step();
        end
        check("mr_quiet", dones, 0);

        // key changes after start have no effect
        fire(KSTD);
        collect("iso", 1'b1);
        check_std_head("iso");
        check("iso_ct", encrypt(PT), CT);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
